fib_hs_responder: RTL and testbench
===================================

# fib_hs_responder

RTL responder for the `ap_ctrl_hs` block-level handshake that our Polyphony-generated testbenches use to drive an HLS `fib` core. It computes the n-th Fibonacci number iteratively and presents the result on `ap_return`. Port names and the start/done/idle/ready protocol match the `fib` instance those benches expect, so this block is a drop-in, cycle-predictable substitute. It sits under the test controller as the callee end of the handshake.

## Interface
- `DATA_WIDTH`, 64: width of `ap_return` and of the internal accumulators. Unsigned arithmetic.
- `N_WIDTH`, 32: width of `n` and of the iteration counter.
- `ap_clk`  in  1  clock; all logic on the rising edge.
- `ap_rst`  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `ap_start`  in  1  start request; sampled only in IDLE.
- `n`  in  N_WIDTH  Fibonacci index, unsigned; captured on the accepted start edge.
- `ap_done`  out  1  one-cycle pulse: result valid.
- `ap_ready`  out  1  one-cycle pulse, identical to `ap_done`. The block is non-pipelined.
- `ap_idle`  out  1  high while in IDLE.
- `ap_return`  out  DATA_WIDTH  fib(n) mod 2^DATA_WIDTH; held until the next accepted result.
- `ap_overflow`  out  1  returned value was truncated; valid and held with `ap_return`.

## Operation
- Definition: fib(0)=0, fib(1)=1, fib(k)=fib(k-1)+fib(k-2).
- Registers:
  - accumulators a and b, DATA_WIDTH each
  - overflow tags oa and ob
  - counter cnt (N_WIDTH)
  - latched index nl (N_WIDTH)
  - result register and result overflow flag
  - 2-bit state register
- States:
  - IDLE: `ap_idle`=1. If `ap_start`=1: nl<=n, a<=0, b<=1, oa<=0, ob<=0, cnt<=0, go LOOP. Otherwise stay.
  - LOOP:
    - If cnt==nl: `ap_return`<=a, `ap_overflow`<=oa, go DONE.
    - Else: a<=b, oa<=ob, b<=a+b (truncated), ob<=ob|carry_out(a+b), cnt<=cnt+1.
  - DONE: `ap_done`=`ap_ready`=1. Always go IDLE; `ap_start` is ignored in this state.
- A new start is accepted only in IDLE. `ap_start` held high through DONE does not restart until IDLE samples it. The caller must therefore drop `ap_start` on the edge where it observes `ap_done`, or it gets a second run.
- Changes on `n` outside the IDLE accept edge have no effect.
- Overflow semantics: the tag follows the value, not the adder.
  - fib(93)=12200160415121876738 fits in 64 bits, so `ap_overflow`=0.
  - fib(94) and above wrap, with `ap_overflow`=1.
- `ap_done`, `ap_ready` and `ap_idle` are decoded from the registered state (no combinational path from inputs).
- Reset:
  - Outputs: `ap_done`=0, `ap_ready`=0, `ap_idle`=1, `ap_return`=0, `ap_overflow`=0.
  - Internal: state=IDLE; a, b, cnt, nl, oa, ob cleared.
  - Reset during LOOP or DONE aborts the run; no done pulse is emitted.
  - Reset wins over a simultaneous `ap_start`.

## Timing
- Let E0 be the edge at which IDLE samples `ap_start`=1.
  - Edges E1..En perform the n iterations.
  - Edge E(n+1) loads the result and enters DONE.
  - `ap_done` is high for exactly the cycle after E(n+1); edge E(n+2) returns to IDLE.
- Latency from E0 to the `ap_done` cycle is n+1 cycles.
  - n=0: `ap_done` in the second cycle after E0, with `ap_return`=0.
- `ap_idle` drops in the cycle after E0 and rises in the cycle after E(n+2).
- Minimum start-to-start interval is n+3 cycles.
- `ap_return` changes only on the E(n+1) edge or on reset.
- cnt never wraps, because cnt≤nl<2^N_WIDTH.

## Structure
- Shared package `fib_hs_pkg`:
  - state encodings ST_IDLE=0, ST_LOOP=1, ST_DONE=2
  - default widths
  - golden constants FIB46=1836311903, FIB47=2971215073, FIB92=7540113804746346429, FIB93=12200160415121876738, for use by benches
- No sub-module: the datapath is a single adder with carry plus a counter compare, so a split adds only wiring.

## Test plan
- Reset held for 10 cycles, then released with `ap_start`=0 → `ap_idle`=1, `ap_done`=0, `ap_return`=0, `ap_overflow`=0 on every cycle.
- Sequential runs with n=0, 46, 47, 92, each with `ap_start` held until `ap_done` → results and latencies:

  | n  | `ap_return`         | `ap_done` cycle after E0 |
  |----|---------------------|--------------------------|
  | 0  | 0                   | 1                        |
  | 46 | 1836311903          | 47                       |
  | 47 | 2971215073          | 48                       |
  | 92 | 7540113804746346429 | 93                       |

  `ap_ready` equals `ap_done` in every run, and `ap_overflow`=0 throughout.
- Overflow runs:
  - n=93 → 12200160415121876738 with `ap_overflow`=0.
  - n=94 → (fib(94) mod 2^64)=1293530146158671551 with `ap_overflow`=1.
- `ap_start` left high across DONE and on into IDLE → no start in DONE; a new run begins at the first IDLE edge, and `ap_done` recurs exactly n+3 cycles after the previous one.
- `n` changed from 10 to 20 one cycle after start → `ap_return`=55, with `ap_done` 11 cycles after E0.
- Reset asserted in the middle of an n=50 run → no `ap_done` pulse; `ap_return`=0 and `ap_idle`=1 the cycle after the reset edge. A following n=1 run returns 1.

Source files
------------

// File: rtl/fib_hs_pkg.sv
// Shared definitions for the fib ap_ctrl_hs responder and its benches.
// Holds default widths, the control-state encoding and golden Fibonacci values.
// No logic lives here.
package fib_hs_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int N_WIDTH_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reference values around the 32-bit and 64-bit wrap points.
  localparam logic [63:0] FIB46 = 64'd1836311903;
  localparam logic [63:0] FIB47 = 64'd2971215073;
  localparam logic [63:0] FIB92 = 64'd7540113804746346429;
  localparam logic [63:0] FIB93 = 64'd12200160415121876738;

endpackage

// File: rtl/fib_hs_responder_if.sv
// ap_ctrl_hs handshake bundle between a test controller and the fib responder.
// master = caller (drives start/n), slave = responder (drives done/ready/idle/result).
// Purely a wiring container; no timing of its own.
interface fib_hs_responder_if
  import fib_hs_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_WIDTH    = N_WIDTH_DEF
);

  logic                  ap_start;
  logic [N_WIDTH-1:0]    n;
  logic                  ap_done;
  logic                  ap_ready;
  logic                  ap_idle;
  logic [DATA_WIDTH-1:0] ap_return;
  logic                  ap_overflow;

  modport master (
    output ap_start, n,
    input  ap_done, ap_ready, ap_idle, ap_return, ap_overflow
  );

  modport slave (
    input  ap_start, n,
    output ap_done, ap_ready, ap_idle, ap_return, ap_overflow
  );

endinterface

// File: rtl/fib_hs_responder.sv
// Iterative fib(n) responder speaking the ap_ctrl_hs start/done/idle/ready handshake.
// Latency: done pulse n+1 cycles after the accepted start edge; start-to-start >= n+3.
// Non-pipelined: ap_start is only sampled in IDLE; held start re-launches after DONE.
module fib_hs_responder
  import fib_hs_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N_WIDTH    = N_WIDTH_DEF
) (
  input logic                ap_clk,
  input logic                ap_rst,
  fib_hs_responder_if.slave  bus
);

  state_t                state;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  oa;
  logic                  ob;
  logic [N_WIDTH-1:0]    cnt;
  logic [N_WIDTH-1:0]    nl;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_ovf;

  // One extra bit catches the carry out of the accumulator add.
  logic [DATA_WIDTH:0]   sum;
  assign sum = {1'b0, a} + {1'b0, b};

  // Control FSM plus datapath: a/b walk the sequence, overflow tags travel with values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= ST_IDLE;
      a          <= '0;
      b          <= '0;
      oa         <= 1'b0;
      ob         <= 1'b0;
      cnt        <= '0;
      nl         <= '0;
      result     <= '0;
      result_ovf <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ap_start) begin
            nl    <= bus.n;
            a     <= '0;
            b     <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            oa    <= 1'b0;
            ob    <= 1'b0;
            cnt   <= '0;
            state <= ST_LOOP;
          end
        end
        ST_LOOP: begin
          if (cnt == nl) begin
            result     <= a;
            result_ovf <= oa;
            state      <= ST_DONE;
          end else begin
            a   <= b;
            oa  <= ob;
            b   <= sum[DATA_WIDTH-1:0];
            ob  <= ob | sum[DATA_WIDTH];
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // Start is deliberately ignored here; only IDLE accepts a new run.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode straight from the state register, so no input-to-output path.
  assign bus.ap_idle     = (state == ST_IDLE);
  assign bus.ap_done     = (state == ST_DONE);
  assign bus.ap_ready    = (state == ST_DONE);
  assign bus.ap_return   = result;
  assign bus.ap_overflow = result_ovf;

endmodule

// File: tb/tb_fib_hs_responder.sv
// Self-checking bench for fib_hs_responder: reset, directed vector table, handshake
// corner sequences and randomized runs against a wide-arithmetic Fibonacci model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_fib_hs_responder;
  import fib_hs_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst;

  always #5 ap_clk = ~ap_clk;

  fib_hs_responder_if #(.DATA_WIDTH(64), .N_WIDTH(32)) bus ();

  fib_hs_responder #(.DATA_WIDTH(64), .N_WIDTH(32)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] n;
    logic [63:0] ret;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: fib(k) in 128-bit arithmetic; truncation flag = true value needs more than 64 bits.
  task automatic ref_fib(input int unsigned k, output logic [63:0] v, output logic o);
    logic [127:0] x, y, t;
    x = 128'd0;
    y = 128'd1;
    for (int unsigned i = 0; i < k; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    v = x[63:0];
    o = |x[127:64];
  endtask

  // Launch one run from IDLE at a falling edge; returns at the falling edge after
  // the done cycle (block back in IDLE), so another run may start immediately.
  task automatic run(input logic [31:0] nv, input logic [31:0] nv_after,
                     output logic [63:0] r, output logic o, output int lat, output bit seen);
    logic [63:0] r_hold;
    seen = 1'b0;
    lat  = 0;
    r    = '0;
    o    = 1'b0;
    bus.ap_start = 1'b1;
    bus.n        = nv;
    @(posedge ap_clk);                       // E0
    @(negedge ap_clk);
    bus.n = nv_after;
    check("idle_drop", {63'd0, bus.ap_idle}, 64'd0);
    while (!seen && lat < int'(nv) + 20) begin
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
      if (bus.ap_done) begin
        seen = 1'b1;
        r    = bus.ap_return;
        o    = bus.ap_overflow;
        check("ready_eq_done", {63'd0, bus.ap_ready}, 64'd1);
        bus.ap_start = 1'b0;
      end
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    r_hold = bus.ap_return;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("post_idle", {62'd0, bus.ap_idle, bus.ap_done}, 64'd2);
    check("ret_held", bus.ap_return, r_hold);
  endtask

  initial begin
    logic [63:0] r, er;
    logic        o, eo;
    int          lat, k;
    bit          seen;
    int          done_cnt;

    vt[0] = '{32'd0,  64'd0,                    1'b0, 1};
    vt[1] = '{32'd1,  64'd1,                    1'b0, 2};
    vt[2] = '{32'd2,  64'd1,                    1'b0, 3};
    vt[3] = '{32'd10, 64'd55,                   1'b0, 11};
    vt[4] = '{32'd46, FIB46,                    1'b0, 47};
    vt[5] = '{32'd47, FIB47,                    1'b0, 48};
    vt[6] = '{32'd92, FIB92,                    1'b0, 93};
    vt[7] = '{32'd93, FIB93,                    1'b0, 94};
    vt[8] = '{32'd94, 64'd1293530146158671551,  1'b1, 95};

    // Reset: outputs at their reset values throughout, and after release with start low.
    ap_rst       = 1'b1;
    bus.ap_start = 1'b1;                     // reset must win over a simultaneous start
    bus.n        = 32'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      check("reset_outs", {59'd0, bus.ap_idle, bus.ap_done, bus.ap_ready, bus.ap_overflow,
                           |bus.ap_return}, 64'h10);
      if (i == 0) bus.ap_start = 1'b0;
    end
    ap_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      check("post_reset_outs", {59'd0, bus.ap_idle, bus.ap_done, bus.ap_ready,
                                bus.ap_overflow, |bus.ap_return}, 64'h10);
    end

    // Directed vector table, run back to back.
    for (int i = 0; i < 9; i++) begin
      run(vt[i].n, vt[i].n, r, o, lat, seen);
      check($sformatf("vec%0d_ret", i), r, vt[i].ret);
      check($sformatf("vec%0d_ovf", i), {63'd0, o}, {63'd0, vt[i].ovf});
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
    end

    // n changes one cycle after the accept edge: the latched value must rule.
    run(32'd10, 32'd20, r, o, lat, seen);
    check("nchg_ret", r, 64'd55);
    check("nchg_lat", 64'(lat), 64'd11);

    // Start held high across DONE: relaunch only from IDLE, done recurs n+3 later.
    bus.ap_start = 1'b1;
    bus.n        = 32'd5;
    @(posedge ap_clk);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge ap_clk);
      seen = bus.ap_done;
      if (!seen) begin
        @(posedge ap_clk);
        k++;
      end
    end
    check("hold_first_done", {63'd0, seen}, 64'd1);
    check("hold_first_ret", bus.ap_return, 64'd5);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(posedge ap_clk);
      k++;
      @(negedge ap_clk);
      seen = bus.ap_done;
    end
    check("hold_second_done", {63'd0, seen}, 64'd1);
    check("hold_spacing", 64'(k), 64'd8);
    bus.ap_start = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);

    // Reset in the middle of an n=50 run: abort with no done pulse.
    bus.ap_start = 1'b1;
    bus.n        = 32'd50;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (bus.ap_done) done_cnt++;
    end
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("abort_outs", {59'd0, bus.ap_idle, bus.ap_done, bus.ap_ready, bus.ap_overflow,
                         |bus.ap_return}, 64'h10);
    ap_rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (bus.ap_done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    run(32'd1, 32'd1, r, o, lat, seen);
    check("after_abort_ret", r, 64'd1);

    // Randomized runs against the model, including random n jitter after accept.
    for (int i = 0; i < 12; i++) begin
      int unsigned nr;
      nr = $urandom_range(0, 110);
      ref_fib(nr, er, eo);
      run(nr, $urandom, r, o, lat, seen);
      check($sformatf("rnd%0d_n%0d_ret", i, nr), r, er);
      check($sformatf("rnd%0d_n%0d_ovf", i, nr), {63'd0, o}, {63'd0, eo});
      check($sformatf("rnd%0d_n%0d_lat", i, nr), 64'(lat), 64'(nr + 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
